// File: rtl/ysyx_22041461_mem_pkg.sv
// ysyx_22041461_mem_pkg: shared types and defaults for the IF/LSU memory-port arbiter.
package ysyx_22041461_mem_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_LSU} owner_e;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/ysyx_22041461_arb_pick.sv
// ysyx_22041461_arb_pick: one-hot grant pick, LSU first unless IF has been starved.
module ysyx_22041461_arb_pick (
    input  logic       if_valid,
    input  logic       lsu_valid,
    input  logic       if_flush,
    input  logic       starved,
    output logic [1:0] grant
);

    logic if_ok;

    always_comb begin
        if_ok    = if_valid & ~if_flush;
        grant[0] = if_ok & (starved | ~lsu_valid);
        grant[1] = lsu_valid & ~(if_ok & starved);
    end

endmodule

// File: rtl/ysyx_22041461_mem_arb.sv
// ysyx_22041461_mem_arb: shares one memory port between IF and LSU, one transaction in flight,
// routing the response back to its owner and discarding flushed fetches.
module ysyx_22041461_mem_arb
    import ysyx_22041461_mem_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    localparam int MW = DATA_W / 8;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CW-1:0]     starve_q, starve_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MW-1:0]     wmask_q, wmask_d;
    logic [1:0]        grant;
    logic              starved, idle, accept, rsp;

    assign starved = starve_q == CW'(STARVE_LIMIT);
    assign idle    = state_q == IDLE;
    assign accept  = idle & |grant;

    ysyx_22041461_arb_pick u_pick (
        .if_valid (if_req_valid),
        .lsu_valid(lsu_req_valid),
        .if_flush (if_flush),
        .starved  (starved),
        .grant    (grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            starve_q <= '0;
            drop_q   <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = mem_req_ready ? WAIT : ISSUE;
            WAIT:    state_d = mem_rsp_valid ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // IF requests carry no write data; a granted fetch always reads
    always_comb begin
        owner_d  = owner_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        drop_d   = drop_q | (!idle && owner_q == OWN_IF && if_flush);
        if (accept) begin
            owner_d  = grant[0] ? OWN_IF : OWN_LSU;
            addr_d   = grant[0] ? if_req_addr : lsu_req_addr;
            wen_d    = grant[1] & lsu_req_wen;
            wdata_d  = grant[0] ? '0 : lsu_req_wdata;
            wmask_d  = grant[0] ? '0 : lsu_req_wmask;
            drop_d   = 1'b0;
            starve_d = (grant[1] && if_req_valid) ? (starved ? starve_q : starve_q + CW'(1)) : '0;
        end
    end

    always_comb begin
        if_req_ready  = rst & idle & grant[0];
        lsu_req_ready = rst & idle & grant[1];
        mem_req_valid = rst & state_q == ISSUE;
        rsp           = rst & state_q == WAIT & mem_rsp_valid;
        if_rsp_valid  = rsp & owner_q == OWN_IF & ~drop_q & ~if_flush;
        lsu_rsp_valid = rsp & owner_q == OWN_LSU;
    end

    assign if_rsp_data   = mem_rsp_data;
    assign lsu_rsp_data  = mem_rsp_data;
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

endmodule

// File: tb/tb_ysyx_22041461_mem_arb.sv
// tb_ysyx_22041461_mem_arb: directed scenarios plus random traffic, checked against a
// transaction-level model of the arbiter.
module tb_ysyx_22041461_mem_arb;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready, if_flush = 1'b0, if_rsp_valid;
    logic [63:0] if_req_addr = '0, if_rsp_data;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_wen = 1'b0, lsu_rsp_valid;
    logic [63:0] lsu_req_addr = '0, lsu_req_wdata = '0, lsu_rsp_data;
    logic [7:0]  lsu_req_wmask = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen, mem_rsp_valid = 1'b0;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_data = '0;
    logic [7:0]  mem_req_wmask;

    int checks = 0;
    int failures = 0;

    // model: phase 0 = free, 1 = request offered downstream, 2 = awaiting response
    int          ph = 0;
    int          starve = 0;
    bit          m_lsu = 0;
    bit          m_drop = 0;
    logic [63:0] m_addr = '0, m_wdata = '0;
    logic        m_wen = 1'b0;
    logic [7:0]  m_wmask = '0;
    byte         glog[$];

    always #5 clk = ~clk;

    ysyx_22041461_mem_arb dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rnd_fields();
        if_req_addr   = {$urandom, $urandom};
        lsu_req_addr  = {$urandom, $urandom};
        lsu_req_wdata = {$urandom, $urandom};
        lsu_req_wmask = 8'($urandom);
        lsu_req_wen   = 1'($urandom);
        mem_rsp_data  = {$urandom, $urandom};
    endtask

    // called just after a rising edge with inputs already driven; checks mid-cycle, then advances
    task automatic tick();
        bit ei, el, ers;
        #4;
        if (!rst) begin
            chk("rst_if_rdy", if_req_ready, 0);
            chk("rst_lsu_rdy", lsu_req_ready, 0);
            chk("rst_mreq_v", mem_req_valid, 0);
            chk("rst_if_rsp", if_rsp_valid, 0);
            chk("rst_lsu_rsp", lsu_rsp_valid, 0);
            ph = 0; starve = 0; m_lsu = 0; m_drop = 0;
            m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0;
        end else begin
            ei = ph == 0 && if_req_valid && !if_flush && (!lsu_req_valid || starve == LIMIT);
            el = ph == 0 && lsu_req_valid && !ei;
            chk("if_rdy", if_req_ready, ei);
            chk("lsu_rdy", lsu_req_ready, el);
            chk("mreq_v", mem_req_valid, ph == 1);
            if (ph == 1) begin
                chk("mreq_addr", mem_req_addr, m_addr);
                chk("mreq_wen", mem_req_wen, m_wen);
                chk("mreq_wdata", mem_req_wdata, m_wdata);
                chk("mreq_wmask", mem_req_wmask, m_wmask);
            end
            ers = ph == 2 && mem_rsp_valid;
            chk("if_rsp_v", if_rsp_valid, ers && !m_lsu && !m_drop && !if_flush);
            chk("lsu_rsp_v", lsu_rsp_valid, ers && m_lsu);
            if (ers) chk("rsp_data", m_lsu ? lsu_rsp_data : if_rsp_data, mem_rsp_data);
            if (if_req_ready && if_req_valid) glog.push_back("I");
            if (lsu_req_ready && lsu_req_valid) glog.push_back("L");
            if (ph != 0 && !m_lsu && if_flush) m_drop = 1;
            if (ph == 0 && ei) begin
                m_lsu = 0; m_addr = if_req_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
                m_drop = 0; starve = 0; ph = 1;
            end else if (ph == 0 && el) begin
                m_lsu = 1; m_addr = lsu_req_addr; m_wen = lsu_req_wen;
                m_wdata = lsu_req_wdata; m_wmask = lsu_req_wmask; m_drop = 0;
                starve = if_req_valid ? (starve < LIMIT ? starve + 1 : LIMIT) : 0;
                ph = 1;
            end else if (ph == 1 && mem_req_ready) ph = 2;
            else if (ph == 2 && mem_rsp_valid) ph = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        if_req_valid = 0; lsu_req_valid = 0; if_flush = 0;
        mem_req_ready = 1; mem_rsp_valid = 1;
        repeat (3) tick();
        mem_rsp_valid = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        if_req_valid = 1; lsu_req_valid = 1; mem_rsp_valid = 1;
        tick();
        tick();
        if_req_valid = 0; lsu_req_valid = 0; mem_rsp_valid = 0;
        rst = 1;
        tick();

        // IF-only fetch with minimum latency
        if_req_valid = 1; if_req_addr = 64'h8000_0000; mem_req_ready = 1;
        tick();
        if_req_valid = 0;
        tick();
        mem_rsp_valid = 1; mem_rsp_data = 64'h0000_0013_0000_0093;
        tick();
        mem_rsp_valid = 0; if_req_valid = 1;
        tick();
        drain();

        // contention and starvation: LSU x4, then IF, then LSU again
        glog.delete();
        if_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1; mem_rsp_valid = 1;
        for (int i = 0; i < 18; i++) begin
            rnd_fields();
            tick();
        end
        drain();
        for (int i = 0; i < 6; i++)
            chk($sformatf("grant_order%0d", i), (glog.size() > i) ? 64'(glog[i]) : 64'd0,
                64'(i == 4 ? "I" : "L"));

        // flush pulsed while waiting: the fetch response must be swallowed
        if_req_valid = 1; mem_req_ready = 1; mem_rsp_valid = 0;
        tick();
        if_req_valid = 0;
        tick();
        if_flush = 1;
        tick();
        if_flush = 0;
        tick();
        mem_rsp_valid = 1;
        tick();
        mem_rsp_valid = 0; if_req_valid = 1; if_flush = 1;
        tick();
        drain();

        // backpressure: fields must stay latched while inputs keep changing
        lsu_req_valid = 1; lsu_req_wen = 1; mem_req_ready = 0;
        tick();
        if_req_valid = 1;
        repeat (5) begin
            rnd_fields();
            tick();
        end
        drain();

        // reset while waiting, then a stray response
        if_req_valid = 1; mem_req_ready = 1;
        tick();
        if_req_valid = 0;
        tick();
        rst = 0; lsu_req_valid = 1;
        tick();
        rst = 1; lsu_req_valid = 0; mem_rsp_valid = 1;
        tick();
        tick();
        mem_rsp_valid = 0;

        for (int i = 0; i < 3000; i++) begin
            rnd_fields();
            if_req_valid  = 1'($urandom_range(0, 2) != 0);
            lsu_req_valid = 1'($urandom_range(0, 1));
            if_flush      = $urandom_range(0, 7) == 0;
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_valid = 1'($urandom_range(0, 1));
            rst           = $urandom_range(0, 199) != 0;
            tick();
        end
        rst = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
